dsp_stream: RTL and testbench

Parametrised pixel-stream DSP stage.
- Scales each incoming pixel by a per-channel signed coefficient fetched from an external synchronous coefficient memory, adds an offset, then rounds, shifts and saturates.
- Emits the result with valid/ready backpressure.
- Generalises the fixed single-channel `dsp` to configurable data width, coefficient width, channel count and memory depth, and adds a register bank, round-robin channel sequencing and output stalling.
- Sits between the pixel source and the encoder, alongside the existing `dsp` instances.

---
 rtl/dsp_stream_pkg.sv | 17 +
 rtl/dsp_sat_round.sv | 37 +++
 rtl/dsp_stream.sv | 240 ++++++++++++++++++++++++
 tb/tb_dsp_stream.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_stream_pkg.sv
// dsp_stream_pkg: shared definitions for the dsp_stream pixel DSP stage.
//   - reg_addr_e : register bank addresses decoded from the 3-bit addr bus
//   - CTRL_*     : bit positions inside the CTRL register
package dsp_stream_pkg;

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_OFFSET = 3'd1,
        REG_SHIFT  = 3'd2,
        REG_BASE   = 3'd3,
        REG_COUNT  = 3'd4
    } reg_addr_e;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_BYPASS = 1;

endpackage

// File: rtl/dsp_sat_round.sv
// dsp_sat_round: combinational round / arithmetic shift / unsigned saturate.
//   din   : signed input of IN_W bits
//   shift : right-shift amount; when non-zero, 2^(shift-1) is added first
//   dout  : result clamped to [0, 2^DATA_W-1]
module dsp_sat_round #(
    parameter int IN_W   = 23,
    parameter int DATA_W = 8
) (
    input  logic signed [IN_W-1:0]   din,
    input  logic        [4:0]        shift,
    output logic        [DATA_W-1:0] dout
);

    // 32 guard bits keep the rounding add free of overflow for any shift
    localparam int EXT_W = IN_W + 32;

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        ext = EXT_W'(din);
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = EXT_W'(1) << (shift - 5'd1);
        end
        shifted = (ext + rnd) >>> shift;
        if (shifted[EXT_W-1]) begin
            dout = '0;
        end else if (|shifted[EXT_W-2:DATA_W]) begin
            dout = '1;
        end else begin
            dout = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/dsp_stream.sv
// dsp_stream: pixel-stream DSP stage. Each accepted pixel is scaled by a
// per-channel signed coefficient from an external 1-cycle-latency memory,
// offset, rounded/shifted/saturated, and emitted with valid/ready.
//   clk, rstn            : clock, async active-low reset
//   en, start_dec        : global accept enable, synchronous restart
//   addr, din, we, dout  : register bank (CTRL, OFFSET, SHIFT, BASE, COUNT)
//   pixel_in, pix_req, pix_ack             : input stream
//   pixel_out, pixel_valid, out_ready, chan_out : output stream
//   memaddr, memdout     : coefficient memory port
//   eno                  : any pipeline stage occupied
module dsp_stream
    import dsp_stream_pkg::*;
#(
    parameter logic RST_VAL  = 1'b0,
    parameter int   DATA_W   = 8,
    parameter int   COEF_W   = 14,
    parameter int   CHANNELS = 4,
    parameter int   MEM_AW   = 6,
    parameter int   BUS_W    = 26,
    localparam int  CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              start_dec,
    input  logic [2:0]        addr,
    input  logic [BUS_W-1:0]  din,
    input  logic              we,
    output logic [BUS_W-1:0]  dout,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pix_req,
    output logic              pix_ack,
    output logic [DATA_W-1:0] pixel_out,
    output logic              pixel_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   chan_out,
    output logic [MEM_AW-1:0] memaddr,
    input  logic [COEF_W-1:0] memdout,
    output logic              eno
);

    localparam int OFF_W  = DATA_W + COEF_W;
    localparam int PROD_W = OFF_W + 1;

    logic [1:0]               ctrl_q, ctrl_d;
    logic signed [OFF_W-1:0]  offset_q, offset_d;
    logic [4:0]               shift_q, shift_d;
    logic [MEM_AW-1:0]        base_q, base_d;
    logic [15:0]              count_q, count_d;
    logic [CH_W-1:0]          chan_cnt_q, chan_cnt_d;

    logic                     s0_valid_q, s0_valid_d;
    logic [DATA_W-1:0]        s0_pix_q, s0_pix_d;
    logic [CH_W-1:0]          s0_chan_q, s0_chan_d;
    logic [MEM_AW-1:0]        memaddr_q, memaddr_d;

    logic                     s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]        s1_pix_q, s1_pix_d;
    logic [CH_W-1:0]          s1_chan_q, s1_chan_d;
    logic                     coef_hold_valid_q, coef_hold_valid_d;
    logic [COEF_W-1:0]        coef_hold_q, coef_hold_d;

    logic                     s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]        s2_pix_q, s2_pix_d;
    logic [CH_W-1:0]          s2_chan_q, s2_chan_d;
    logic signed [PROD_W-1:0] s2_sum_q, s2_sum_d;

    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_pix_q, out_pix_d;
    logic [CH_W-1:0]          out_chan_q, out_chan_d;

    logic                     stall, accept;
    logic signed [COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] coef_ext, pix_ext, sum;
    logic [DATA_W-1:0]        sat_pix;
    logic                     unused_din;

    assign unused_din  = ^din;
    assign stall       = out_valid_q & ~out_ready;
    assign pix_ack     = ctrl_q[CTRL_ENABLE] & en & ~stall;
    assign accept      = pix_req & pix_ack & ~start_dec;
    assign memaddr     = memaddr_q;
    assign pixel_out   = out_pix_q;
    assign pixel_valid = out_valid_q;
    assign chan_out    = out_chan_q;
    assign eno         = s0_valid_q | s1_valid_q | s2_valid_q | out_valid_q;

    // The memory re-reads S0's address while stalled, so S1's coefficient is
    // captured on the first stalled edge and used until the stall clears.
    always_comb begin
        coef     = coef_hold_valid_q ? $signed(coef_hold_q) : $signed(memdout);
        coef_ext = PROD_W'(coef);
        pix_ext  = PROD_W'({1'b0, s1_pix_q});
        sum      = coef_ext * pix_ext + PROD_W'(offset_q);
    end

    dsp_sat_round #(
        .IN_W   (PROD_W),
        .DATA_W (DATA_W)
    ) u_sat_round (
        .din   (s2_sum_q),
        .shift (shift_q),
        .dout  (sat_pix)
    );

    always_comb begin
        dout = '0;
        case (addr)
            REG_CTRL:   dout = BUS_W'(ctrl_q);
            REG_OFFSET: dout = BUS_W'(offset_q);
            REG_SHIFT:  dout = BUS_W'(shift_q);
            REG_BASE:   dout = BUS_W'(base_q);
            REG_COUNT:  dout = BUS_W'(count_q);
            default:    dout = '0;
        endcase
    end

    always_comb begin
        ctrl_d            = ctrl_q;
        offset_d          = offset_q;
        shift_d           = shift_q;
        base_d            = base_q;
        count_d           = count_q;
        chan_cnt_d        = chan_cnt_q;
        s0_valid_d        = s0_valid_q;
        s0_pix_d          = s0_pix_q;
        s0_chan_d         = s0_chan_q;
        memaddr_d         = memaddr_q;
        s1_valid_d        = s1_valid_q;
        s1_pix_d          = s1_pix_q;
        s1_chan_d         = s1_chan_q;
        coef_hold_valid_d = coef_hold_valid_q;
        coef_hold_d       = coef_hold_q;
        s2_valid_d        = s2_valid_q;
        s2_pix_d          = s2_pix_q;
        s2_chan_d         = s2_chan_q;
        s2_sum_d          = s2_sum_q;
        out_valid_d       = out_valid_q;
        out_pix_d         = out_pix_q;
        out_chan_d        = out_chan_q;

        if (we) begin
            case (addr)
                REG_CTRL:   ctrl_d   = din[1:0];
                REG_OFFSET: offset_d = OFF_W'($signed(din));
                REG_SHIFT:  shift_d  = din[4:0];
                REG_BASE:   base_d   = din[MEM_AW-1:0];
                default:    ;
            endcase
        end

        if (accept) begin
            count_d    = count_q + 16'd1;
            s0_pix_d   = pixel_in;
            s0_chan_d  = chan_cnt_q;
            memaddr_d  = base_q + MEM_AW'(chan_cnt_q);
            chan_cnt_d = (chan_cnt_q == CH_W'(CHANNELS - 1)) ? '0 : chan_cnt_q + CH_W'(1);
        end

        if (!stall) begin
            s0_valid_d        = accept;
            s1_valid_d        = s0_valid_q;
            s1_pix_d          = s0_pix_q;
            s1_chan_d         = s0_chan_q;
            s2_valid_d        = s1_valid_q;
            s2_pix_d          = s1_pix_q;
            s2_chan_d         = s1_chan_q;
            s2_sum_d          = sum;
            out_valid_d       = s2_valid_q;
            coef_hold_valid_d = 1'b0;
            if (s2_valid_q) begin
                out_pix_d  = ctrl_q[CTRL_BYPASS] ? s2_pix_q : sat_pix;
                out_chan_d = s2_chan_q;
            end
        end else if (!coef_hold_valid_q) begin
            coef_hold_valid_d = 1'b1;
            coef_hold_d       = memdout;
        end

        if (start_dec) begin
            s0_valid_d        = 1'b0;
            s1_valid_d        = 1'b0;
            s2_valid_d        = 1'b0;
            out_valid_d       = 1'b0;
            coef_hold_valid_d = 1'b0;
            chan_cnt_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q            <= {1'b0, RST_VAL};
            offset_q          <= '0;
            shift_q           <= '0;
            base_q            <= '0;
            count_q           <= '0;
            chan_cnt_q        <= '0;
            s0_valid_q        <= 1'b0;
            s0_pix_q          <= '0;
            s0_chan_q         <= '0;
            memaddr_q         <= '0;
            s1_valid_q        <= 1'b0;
            s1_pix_q          <= '0;
            s1_chan_q         <= '0;
            coef_hold_valid_q <= 1'b0;
            coef_hold_q       <= '0;
            s2_valid_q        <= 1'b0;
            s2_pix_q          <= '0;
            s2_chan_q         <= '0;
            s2_sum_q          <= '0;
            out_valid_q       <= 1'b0;
            out_pix_q         <= '0;
            out_chan_q        <= '0;
        end else begin
            ctrl_q            <= ctrl_d;
            offset_q          <= offset_d;
            shift_q           <= shift_d;
            base_q            <= base_d;
            count_q           <= count_d;
            chan_cnt_q        <= chan_cnt_d;
            s0_valid_q        <= s0_valid_d;
            s0_pix_q          <= s0_pix_d;
            s0_chan_q         <= s0_chan_d;
            memaddr_q         <= memaddr_d;
            s1_valid_q        <= s1_valid_d;
            s1_pix_q          <= s1_pix_d;
            s1_chan_q         <= s1_chan_d;
            coef_hold_valid_q <= coef_hold_valid_d;
            coef_hold_q       <= coef_hold_d;
            s2_valid_q        <= s2_valid_d;
            s2_pix_q          <= s2_pix_d;
            s2_chan_q         <= s2_chan_d;
            s2_sum_q          <= s2_sum_d;
            out_valid_q       <= out_valid_d;
            out_pix_q         <= out_pix_d;
            out_chan_q        <= out_chan_d;
        end
    end

endmodule

// File: tb/tb_dsp_stream.sv
// tb_dsp_stream: directed-vector bench for dsp_stream with a scoreboard
// queue filled at acceptance and drained by an independent output monitor.
module tb_dsp_stream;

    localparam int DATA_W   = 8;
    localparam int COEF_W   = 14;
    localparam int CHANNELS = 4;
    localparam int MEM_AW   = 6;
    localparam int BUS_W    = 26;

    logic              clk;
    logic              rstn;
    logic              en;
    logic              start_dec;
    logic [2:0]        addr;
    logic [BUS_W-1:0]  din;
    logic              we;
    logic [BUS_W-1:0]  dout;
    logic [DATA_W-1:0] pixel_in;
    logic              pix_req;
    logic              pix_ack;
    logic [DATA_W-1:0] pixel_out;
    logic              pixel_valid;
    logic              out_ready;
    logic [1:0]        chan_out;
    logic [MEM_AW-1:0] memaddr;
    logic [COEF_W-1:0] memdout;
    logic              eno;

    logic signed [COEF_W-1:0] mem [64];

    typedef struct {
        logic [7:0] pix;
        logic [1:0] chan;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   exp_chan = 0;
    int   cur_base = 0;
    int   n_acc = 0;

    dsp_stream #(
        .RST_VAL  (1'b0),
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .CHANNELS (CHANNELS),
        .MEM_AW   (MEM_AW),
        .BUS_W    (BUS_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .start_dec   (start_dec),
        .addr        (addr),
        .din         (din),
        .we          (we),
        .dout        (dout),
        .pixel_in    (pixel_in),
        .pix_req     (pix_req),
        .pix_ack     (pix_ack),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .out_ready   (out_ready),
        .chan_out    (chan_out),
        .memaddr     (memaddr),
        .memdout     (memdout),
        .eno         (eno)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        memdout <= mem[memaddr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Output monitor: a transfer happens on the coming edge when valid & ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && pixel_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got pixel %0d chan %0d, expected none",
                             pixel_out, chan_out);
                end else begin
                    e = sb.pop_front();
                    chk("pixel_out", int'(pixel_out), int'(e.pix));
                    chk("chan_out", int'(chan_out), int'(e.chan));
                    if (e.lat) chk("latency", cyc - e.acc, 3);
                end
            end
        end
    end

    task automatic wr(input int a, input logic [BUS_W-1:0] d);
        @(negedge clk);
        addr = 3'(a);
        din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input int a, input int exp);
        @(negedge clk);
        addr = 3'(a);
        #1;
        chk(nm, int'(dout), exp);
    endtask

    // Present one pixel until accepted; ends just after the accepting edge.
    task automatic send(input int pix, input int exp_pix, input bit lat,
                        input bit push, input int exp_maddr);
        int unsigned waited = 0;
        bit done = 1'b0;
        @(negedge clk);
        pixel_in = 8'(pix);
        pix_req  = 1'b1;
        while (!done) begin
            #1;
            if (pix_ack) begin
                if (push) sb.push_back('{pix: 8'(exp_pix), chan: 2'(exp_chan), acc: cyc + 1, lat: lat});
                exp_chan = (exp_chan + 1) % CHANNELS;
                n_acc++;
                done = 1'b1;
                @(posedge clk);
                #1;
                if (exp_maddr >= 0) chk("memaddr", int'(memaddr), exp_maddr);
            end else if (waited > 200) begin
                chk("ack_timeout", int'(pix_ack), 1);
                done = 1'b1;
            end else begin
                waited++;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        pix_req = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while ((sb.size() != 0 || eno) && t < 100) begin
            @(negedge clk);
            t++;
        end
        #3;
        chk("drain_queue", sb.size(), 0);
        chk("drain_eno", int'(eno), 0);
    endtask

    task automatic one(input int pix, input int coef, input int exp_pix);
        mem[(cur_base + exp_chan) % 64] = COEF_W'(coef);
        send(pix, exp_pix, 1'b1, 1'b1, -1);
        idle();
        drain();
    endtask

    task automatic restart();
        @(negedge clk);
        pix_req   = 1'b0;
        start_dec = 1'b1;
        @(negedge clk);
        start_dec = 1'b0;
        exp_chan  = 0;
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        rstn = 1'b0; en = 1'b1; start_dec = 1'b0; addr = '0; din = '0; we = 1'b0;
        pixel_in = '0; pix_req = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Reset state
        #3;
        chk("rst_pixel_out", int'(pixel_out), 0);
        chk("rst_pixel_valid", int'(pixel_valid), 0);
        chk("rst_chan_out", int'(chan_out), 0);
        chk("rst_memaddr", int'(memaddr), 0);
        chk("rst_eno", int'(eno), 0);
        chk("rst_pix_ack", int'(pix_ack), 0);
        for (int a = 0; a < 5; a++) begin
            addr = 3'(a);
            #1;
            chk("rst_dout", int'(dout), 0);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Register bank
        wr(0, 26'd1);
        rd_chk("ctrl_rd", 0, 1);
        chk("pix_ack_en", int'(pix_ack), 1);
        en = 1'b0;
        #1;
        chk("pix_ack_gated", int'(pix_ack), 0);
        en = 1'b1;
        wr(1, 26'h0200000);
        rd_chk("offset_signext", 1, 26'h3E00000);
        wr(1, 26'd0);
        wr(5, 26'h123);
        rd_chk("addr5_rd", 5, 0);
        rd_chk("addr7_rd", 7, 0);
        wr(2, 26'd6);
        rd_chk("shift_rd", 2, 6);
        wr(3, 26'd0);

        // Scale, saturation, rounding, offset, bypass
        one(100, 64, 100);
        one(200, 512, 255);
        one(100, -64, 0);
        wr(2, 26'd1);
        one(3, 1, 2);
        wr(2, 26'd0);
        wr(1, 26'h3FFFFFA);
        one(10, 1, 4);
        wr(0, 26'd3);
        one(77, 5, 77);
        wr(0, 26'd1);
        wr(1, 26'd0);
        wr(2, 26'd6);

        // Channel sequencing with BASE wrap
        wr(3, 26'd62);
        cur_base = 62;
        mem[62] = 14'sd64; mem[63] = 14'sd128; mem[0] = 14'sd32; mem[1] = 14'sd16;
        restart();
        send(10, 10, 1'b1, 1'b1, 62);
        send(20, 40, 1'b1, 1'b1, 63);
        send(30, 15, 1'b1, 1'b1, 0);
        send(40, 10, 1'b1, 1'b1, 1);
        send(50, 50, 1'b1, 1'b1, 62);
        idle();
        drain();

        // Backpressure: out_ready low for 5 cycles mid-stream
        restart();
        fork
            begin
                send(11, 11, 1'b0, 1'b1, -1);
                send(12, 24, 1'b0, 1'b1, -1);
                send(13, 7, 1'b0, 1'b1, -1);
                send(14, 4, 1'b0, 1'b1, -1);
                send(15, 15, 1'b0, 1'b1, -1);
                send(16, 32, 1'b0, 1'b1, -1);
                send(17, 9, 1'b0, 1'b1, -1);
                send(18, 5, 1'b0, 1'b1, -1);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                #1;
                chk("stall_pix_ack", int'(pix_ack), 0);
                chk("stall_valid", int'(pixel_valid), 1);
                chk("stall_eno", int'(eno), 1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Restart with two pixels in flight
        send(60, 0, 1'b0, 1'b0, -1);
        send(61, 0, 1'b0, 1'b0, -1);
        restart();
        repeat (6) @(negedge clk);
        chk("restart_valid", int'(pixel_valid), 0);
        chk("restart_eno", int'(eno), 0);
        send(100, 100, 1'b1, 1'b1, 62);
        idle();
        drain();

        // COUNT write collides with an acceptance
        @(negedge clk);
        pixel_in = 8'd20; pix_req = 1'b1; we = 1'b1; addr = 3'd4; din = 26'h55;
        #1;
        chk("count_coll_ack", int'(pix_ack), 1);
        sb.push_back('{pix: 8'd40, chan: 2'(exp_chan), acc: cyc + 1, lat: 1'b1});
        exp_chan = (exp_chan + 1) % CHANNELS;
        n_acc++;
        @(negedge clk);
        pix_req = 1'b0; we = 1'b0;
        rd_chk("count_rd", 4, n_acc);
        drain();

        // Asynchronous reset mid-stream
        @(negedge clk);
        pixel_in = 8'd9; pix_req = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_pixel_out", int'(pixel_out), 0);
        chk("arst_pixel_valid", int'(pixel_valid), 0);
        chk("arst_chan_out", int'(chan_out), 0);
        chk("arst_memaddr", int'(memaddr), 0);
        chk("arst_eno", int'(eno), 0);
        chk("arst_pix_ack", int'(pix_ack), 0);
        pix_req = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        rd_chk("arst_ctrl", 0, 0);
        rd_chk("arst_count", 4, 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
